// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: Wishbone-classic slave to reg-bus bridge with ack timeout and sticky error capture
module uart_reg_bridge #(
  parameter int          TO_CYCLES = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_DEAD
) (
  input  logic        app_clk,
  input  logic        arst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [8:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        reg_cs,
  output logic        reg_wr,
  output logic [8:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  input  logic        cfg_err_clr,
  output logic        err_sticky,
  output logic [8:0]  err_addr
);
  localparam int CW = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic aborted, start, done_ack, done_to, drop;
  // Completion decode and next state; ack beats a same-cycle expiry
  always_comb begin
    start    = (state == IDLE) && wbs_cyc_i && wbs_stb_i;
    done_ack = (state == REQ) && reg_ack;
    done_to  = (state == REQ) && !reg_ack && (TO_CYCLES != 0) && (cnt == '0);
    drop     = aborted || !wbs_cyc_i;
    state_nx = (state == RESP) ? IDLE :
               start ? REQ :
               (done_ack || done_to) ? RESP : state;
  end
  // State register
  always_ff @(posedge app_clk or negedge arst_n)
    if (!arst_n) state <= IDLE;
    else state <= state_nx;
  // Request capture, timeout counter, response and error bookkeeping
  always_ff @(posedge app_clk or negedge arst_n)
    if (!arst_n) begin
      reg_cs     <= 1'b0;
      reg_wr     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_be     <= '0;
      cnt        <= '0;
      aborted    <= 1'b0;
      wbs_dat_o  <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_err_o  <= 1'b0;
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else begin
      wbs_ack_o <= done_ack && !drop;
      wbs_err_o <= done_to && !drop;
      if (start) begin
        reg_cs    <= 1'b1;
        reg_wr    <= wbs_we_i;
        reg_addr  <= wbs_adr_i;
        reg_wdata <= wbs_dat_i;
        reg_be    <= wbs_sel_i;
        cnt       <= CW'(TO_CYCLES);
        aborted   <= 1'b0;
      end else if (state == REQ) begin
        if (!wbs_cyc_i) aborted <= 1'b1;
        if (!reg_ack && cnt != '0) cnt <= cnt - CW'(1);
        if (done_ack || done_to) reg_cs <= 1'b0;
      end
      if (done_ack) wbs_dat_o <= reg_wr ? '0 : reg_rdata;
      else if (done_to) wbs_dat_o <= ERR_DATA;
      if (done_to) begin
        err_sticky <= 1'b1;
        err_addr   <= reg_addr;
      end else if (cfg_err_clr) err_sticky <= 1'b0;
    end
endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge: table-driven accesses with a response scoreboard for uart_reg_bridge
module tb_uart_reg_bridge;
  logic        app_clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [8:0]  wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o;
  logic        reg_cs, reg_wr;
  logic [8:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata = '0;
  logic        reg_ack = 1'b0;
  logic        cfg_err_clr = 1'b0;
  logic        err_sticky;
  logic [8:0]  err_addr;

  uart_reg_bridge #(.TO_CYCLES(4), .ERR_DATA(32'hDEAD_DEAD)) dut (
    .app_clk(app_clk), .arst_n(arst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .cfg_err_clr(cfg_err_clr), .err_sticky(err_sticky), .err_addr(err_addr)
  );

  always #5 app_clk = ~app_clk;

  typedef struct {
    logic        we;
    logic [8:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          ack;
    int          drop;
    logic        late;
    logic        vis;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          resp;
    int          cs_last;
    logic        exp_sticky;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          cyc;
  } rsp_t;

  rsp_t sb[$];
  vec_t vecs[6];
  int n_chk = 0;
  int n_fail = 0;
  int cur_cycle = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge app_clk)
    if (wbs_ack_o || wbs_err_o) begin
      rsp_t e;
      if (sb.size() == 0) chk("unexpected_rsp", {wbs_ack_o, wbs_err_o}, 2'b00);
      else begin
        e = sb.pop_front();
        chk("rsp_kind", {wbs_ack_o, wbs_err_o}, {!e.err, e.err});
        chk("rsp_dat", wbs_dat_o, e.dat);
        chk("rsp_cycle", cur_cycle, e.cyc);
      end
    end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_reg_cs"}, reg_cs, 0);
    chk({tag, "_reg_wr"}, reg_wr, 0);
    chk({tag, "_reg_addr"}, reg_addr, 0);
    chk({tag, "_reg_wdata"}, reg_wdata, 0);
    chk({tag, "_reg_be"}, reg_be, 0);
    chk({tag, "_wbs_dat_o"}, wbs_dat_o, 0);
    chk({tag, "_ack_err"}, {wbs_ack_o, wbs_err_o}, 0);
    chk({tag, "_err_sticky"}, err_sticky, 0);
    chk({tag, "_err_addr"}, err_addr, 0);
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge app_clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = v.we;
    wbs_adr_i = v.adr; wbs_dat_i = v.dat; wbs_sel_i = v.sel; reg_rdata = v.rdata;
    if (v.vis) sb.push_back('{v.exp_err, v.exp_dat, v.resp});
    @(posedge app_clk);
    for (int c = 1; c <= v.resp + 1; c++) begin
      #1;
      cur_cycle = c;
      wbs_cyc_i = (c <= v.resp) && (v.drop == 0 || c < v.drop);
      wbs_stb_i = wbs_cyc_i;
      reg_ack = (c == v.ack) || (v.late && c >= v.resp);
      @(negedge app_clk);
      chk("reg_cs", reg_cs, c <= v.cs_last);
      if (c <= v.cs_last) begin
        chk("reg_addr", reg_addr, v.adr);
        chk("reg_wr", reg_wr, v.we);
        chk("reg_be", reg_be, v.sel);
        chk("reg_wdata", reg_wdata, v.dat);
      end
      @(posedge app_clk);
    end
    #1;
    cur_cycle = -1;
    reg_ack = 1'b0;
    chk("rsp_missing", sb.size(), 0);
    sb.delete();
    chk("err_sticky", err_sticky, v.exp_sticky);
    if (v.exp_err) chk("err_addr", err_addr, v.adr);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 9'h048, 32'h0000_00A5, 4'b0001, 32'hFFFF_FFFF, 3, 0, 1'b0, 1'b1, 1'b0, 32'h0, 4, 3, 1'b0};
    vecs[1] = '{1'b0, 9'h090, 32'h0, 4'b1111, 32'h1234_5678, 1, 0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 2, 1, 1'b0};
    vecs[2] = '{1'b0, 9'h0C0, 32'h0, 4'b1111, 32'h5555_5555, 0, 0, 1'b1, 1'b1, 1'b1, 32'hDEAD_DEAD, 6, 5, 1'b1};
    vecs[3] = '{1'b0, 9'h100, 32'h0, 4'b1111, 32'hCAFE_F00D, 5, 0, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 6, 5, 1'b0};
    vecs[4] = '{1'b1, 9'h1C4, 32'h0000_55AA, 4'b1111, 32'h0, 4, 2, 1'b0, 1'b0, 1'b0, 32'h0, 5, 4, 1'b0};
    vecs[5] = '{1'b1, 9'h07C, 32'h1122_3344, 4'b1100, 32'h8765_4321, 2, 0, 1'b0, 1'b1, 1'b0, 32'h0, 3, 2, 1'b0};
    #2 arst_n = 1'b0;
    #1 check_reset_vals("por");
    repeat (2) @(posedge app_clk);
    #1 arst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      if (i == 2) begin
        @(posedge app_clk); #1 cfg_err_clr = 1'b1;
        @(posedge app_clk); #1 cfg_err_clr = 1'b0;
        @(negedge app_clk);
        chk("clr_sticky", err_sticky, 0);
        chk("clr_keeps_err_addr", err_addr, 9'h0C0);
      end
    end
    @(posedge app_clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 9'h0AC; wbs_dat_i = 32'hFEED_BEEF; wbs_sel_i = 4'b0011;
    @(posedge app_clk); #1;
    chk("mid_cs_before_reset", reg_cs, 1);
    @(posedge app_clk); #1;
    arst_n = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    #1 check_reset_vals("mid");
    @(posedge app_clk); #1 arst_n = 1'b1;
    repeat (3) @(posedge app_clk);
    chk("no_rsp_after_reset", sb.size(), 0);
    run_vec(vecs[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
